// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port among NUM_SRC Avalon-ST sources.
// Define FIFO_ARB_PKT_LOCK_EN to hold each grant until eop; without it the grant rotates after every beat.
//   state | meaning
//   IDLE  | no grant; pick next valid source starting at rr_ptr
//   BUSY  | one source granted; its beats pass to the FIFO under full backpressure
module fifo_wr_arbiter #(
  parameter int DATABITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_PER_BEAT    = 4,
  parameter int WIDTH               = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  parameter int NUM_SRC             = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  input  logic [NUM_SRC-1:0]       src_sop_i,
  input  logic [NUM_SRC-1:0]       src_eop_i,
  output logic [NUM_SRC-1:0]       src_ready_o,
  output logic [WIDTH-1:0]         fifo_data_o,
  output logic                     fifo_wr_o,
  input  logic                     fifo_full_i,
  output logic [NUM_SRC-1:0]       grant_o,
  output logic [15:0]              pkt_cnt_o
);

  localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nx;
  logic [NUM_SRC-1:0] grant, grant_nx;
  logic [IDXW-1:0]    rr_ptr, rr_ptr_nx;
  logic [IDXW-1:0]    gidx, gidx_nx;
  logic [IDXW-1:0]    pick;
  logic [15:0]        pkt_cnt, pkt_cnt_nx;
  logic               found;
  logic               accept;
  logic               last_beat;
  logic               release_now;
  logic               unused_sop;

  // sop carries no meaning for arbitration; only eop ends a packet
  assign unused_sop = ^src_sop_i;

  function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return IDXW'(sum);
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && src_valid_i[wrap_idx(rr_ptr, i)]) begin
        found = 1'b1;
        pick  = wrap_idx(rr_ptr, i);
      end
    end
  end

  always_comb begin
    fifo_data_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (state == BUSY && gidx == IDXW'(k)) fifo_data_o = src_data_i[k*WIDTH +: WIDTH];
    end
  end

  assign accept    = (state == BUSY) && src_valid_i[gidx] && !fifo_full_i;
  assign last_beat = src_eop_i[gidx];

`ifdef FIFO_ARB_PKT_LOCK_EN
  assign release_now = accept && last_beat;
`else
  assign release_now = accept;
`endif

  assign fifo_wr_o   = accept;
  assign src_ready_o = (state == BUSY && !fifo_full_i) ? grant : '0;
  assign grant_o     = grant;
  assign pkt_cnt_o   = pkt_cnt;

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    rr_ptr_nx  = rr_ptr;
    gidx_nx    = gidx;
    pkt_cnt_nx = pkt_cnt;
    if (accept && last_beat) pkt_cnt_nx = pkt_cnt + 16'd1;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx       = BUSY;
          grant_nx       = '0;
          grant_nx[pick] = 1'b1;
          gidx_nx        = pick;
          rr_ptr_nx      = wrap_idx(pick, 1);
        end
      end
      BUSY: begin
        if (release_now) begin
          state_nx = IDLE;
          grant_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      gidx    <= '0;
      pkt_cnt <= '0;
    end else begin
      state   <= state_nx;
      grant   <= grant_nx;
      rr_ptr  <= rr_ptr_nx;
      gidx    <= gidx_nx;
      pkt_cnt <= pkt_cnt_nx;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized sources and a queue-based arbitration model feeding a scoreboard.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int N = 3;
  localparam int W = 32;
`ifdef FIFO_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N*W-1:0] src_data;
  logic [N-1:0] src_valid, src_sop, src_eop, src_ready;
  logic [W-1:0] fifo_data;
  logic         fifo_wr, fifo_full;
  logic [N-1:0] grant;
  logic [15:0]  pkt_cnt;

  fifo_wr_arbiter #(.DATABITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(4), .NUM_SRC(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .src_data_i(src_data), .src_valid_i(src_valid), .src_sop_i(src_sop), .src_eop_i(src_eop),
    .src_ready_o(src_ready),
    .fifo_data_o(fifo_data), .fifo_wr_o(fifo_wr), .fifo_full_i(fifo_full),
    .grant_o(grant), .pkt_cnt_o(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic sop; logic eop; logic [W-1:0] data;} beat_t;

  beat_t        srcq [N][$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           failures = 0;

  int  gap [N];
  bit  pres[N];
  int  gap_max = 0;
  int  full_pct = 0;
  int  full_force = 0;
  logic [N-1:0] acc;
  beat_t drv_b;

  // reference model state: integer grant index and round-robin pointer
  bit          m_busy = 0;
  int          m_g = 0;
  int          m_rr = 0;
  logic [15:0] m_pkt = 0;
  logic [N-1:0] e_grant = 0, e_ready = 0;
  logic [W-1:0] e_data = 0;
  logic         e_wr = 0;
  logic [15:0]  e_pkt = 0;
  logic [N-1:0] one = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_pkt(input int k, input int len, input logic [W-1:0] base, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? W'($urandom) : base + W'(i);
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      srcq[k].push_back(b);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += srcq[k].size();
    return s;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((pending() > 0 || m_busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check(name, n < budget, 1);
  endtask

  // source driver: holds each beat until the DUT accepts it, optional gaps between beats
  initial begin
    src_valid = '0; src_data = '0; src_sop = '0; src_eop = '0; fifo_full = 1'b0;
    for (int k = 0; k < N; k++) begin gap[k] = 0; pres[k] = 0; end
    forever begin
      @(negedge clk); #2;
      acc = src_valid & src_ready;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && pres[k]) begin
          void'(srcq[k].pop_front());
          pres[k] = 0;
          gap[k]  = $urandom_range(0, gap_max);
        end
        if (!pres[k] && srcq[k].size() > 0) begin
          if (gap[k] > 0) gap[k]--;
          else pres[k] = 1;
        end
        if (pres[k]) begin
          drv_b = srcq[k][0];
          src_valid[k] = 1'b1;
          src_data[k*W +: W] = drv_b.data;
          src_sop[k] = drv_b.sop;
          src_eop[k] = drv_b.eop;
        end else begin
          src_valid[k] = 1'b0;
          src_data[k*W +: W] = W'($urandom);
          src_sop[k] = 1'b0;
          src_eop[k] = 1'b0;
        end
      end
      if (full_force > 0) begin
        fifo_full = 1'b1;
        full_force--;
      end else begin
        fifo_full = ($urandom_range(0, 99) < full_pct);
      end
    end
  end

  // reference model: predicts this cycle's outputs, queues expected FIFO beats
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; m_g = 0; m_rr = 0; m_pkt = 0;
        e_grant = '0; e_ready = '0; e_data = '0; e_wr = 1'b0; e_pkt = '0;
        exp_q.delete();
        continue;
      end
      e_pkt   = m_pkt;
      e_grant = m_busy ? (one << m_g) : '0;
      e_ready = (m_busy && !fifo_full) ? e_grant : '0;
      e_data  = m_busy ? src_data[m_g*W +: W] : '0;
      e_wr    = m_busy && src_valid[m_g] && !fifo_full;
      if (e_wr) begin
        exp_q.push_back(e_data);
        if (src_eop[m_g]) m_pkt++;
        if (src_eop[m_g] || !LOCK) m_busy = 0;
      end else if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_rr + i) % N;
          if (src_valid[c]) begin
            m_g = c;
            m_rr = (c + 1) % N;
            m_busy = 1;
            break;
          end
        end
      end
    end
  end

  // monitor: compares DUT outputs and pops the scoreboard on every FIFO write
  initial begin
    forever begin
      @(negedge clk); #1;
      check("grant", grant, e_grant);
      check("ready", src_ready, e_ready);
      check("fifo_data", fifo_data, e_data);
      check("fifo_wr", fifo_wr, e_wr);
      check("pkt_cnt", pkt_cnt, e_pkt);
      if (fifo_wr) begin
        check("scoreboard_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("beat", fifo_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] prev_g;
    int n, got;
    bit seen;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);

    // single source, 4-beat packet 0x11..0x14
    push_pkt(1, 4, 32'h11, 0);
    drain("drain_src1", 100);
    check("pkt_cnt_after_src1", pkt_cnt, 1);

    // full held 5 cycles in the middle of a src2 packet
    push_pkt(2, 6, 32'h2000_0000, 0);
    seen = 0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk); #1;
      n++;
      if (fifo_wr && grant == 3'b100) seen = 1;
    end
    check("wait_src2_write", seen, 1);
    full_force = 5;
    drain("drain_full", 200);

    // all sources with back-to-back 2-beat packets: rotation 0,1,2,0,1,2
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push_pkt(k, 2, W'(32'h100 * (k + 1) + 32'h10 * r), 0);
    prev_g = '0; got = 0; n = 0;
    while (got < 6 && n < 100) begin
      @(negedge clk); #1;
      n++;
      if (grant != '0 && prev_g == '0) begin
        check($sformatf("grant_order%0d", got), grant, one << (got % 3));
        got++;
      end
      prev_g = grant;
    end
    check("grant_order_count", got, 6);
    drain("drain_rr", 200);

    // asynchronous reset pulse between clock edges, mid-packet
    for (int k = 0; k < N; k++) push_pkt(k, 4, $urandom, 1);
    for (int k = 0; k < N; k++) push_pkt(k, 4, $urandom, 1);
    seen = 0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk); #1;
      n++;
      if (fifo_wr) seen = 1;
    end
    check("wait_write_before_rst", seen, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    m_busy = 0; m_g = 0; m_rr = 0; m_pkt = 0;
    e_grant = '0; e_ready = '0; e_data = '0; e_wr = 1'b0; e_pkt = '0;
    exp_q.delete();
    #0.5;
    check("rst_async_grant", grant, 0);
    check("rst_async_pkt_cnt", pkt_cnt, 0);
    check("rst_async_wr", fifo_wr, 0);
    #0.5 rst = 1'b0;
    seen = 0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk); #1;
      n++;
      if (grant != '0) seen = 1;
    end
    check("first_grant_after_rst", grant, 3'b001);
    drain("drain_rst", 400);

    // randomized traffic with valid gaps and random backpressure
    gap_max = 2;
    full_pct = 20;
    for (int p = 0; p < 24; p++) push_pkt($urandom_range(0, N - 1), $urandom_range(1, 5), '0, 1);
    drain("drain_random", 3000);
    full_pct = 0;
    gap_max = 0;
    repeat (5) @(posedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    check("pkt_cnt_final", pkt_cnt, m_pkt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
